// File: rtl/l2_req_out_queue.sv
// Elastic request-out FIFO between l2_core and the NoC, with occupancy
// reporting and a drain-done handshake used by fence handling.
module l2_req_out_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MSG_W   = 5,
  parameter int unsigned HPROT_W = 1,
  parameter int unsigned ADDR_W  = 26,
  parameter int unsigned LINE_W  = 128,
  parameter int unsigned WMASK_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MSG_W-1:0]           in_coh_msg,
  input  logic [HPROT_W-1:0]         in_hprot,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [LINE_W-1:0]          in_line,
  input  logic [WMASK_W-1:0]         in_word_mask,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MSG_W-1:0]           out_coh_msg,
  output logic [HPROT_W-1:0]         out_hprot,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [LINE_W-1:0]          out_line,
  output logic [WMASK_W-1:0]         out_word_mask,
  input  logic                       drain_req,
  output logic                       drain_done,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = MSG_W + HPROT_W + ADDR_W + LINE_W + WMASK_W;

  typedef enum logic [1:0] {
    DR_IDLE,
    DR_WAIT,
    DR_DONE,
    DR_HOLD
  } drain_state_e;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  drain_state_e     drain_q, drain_d;
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] head;
  logic             push, pop;

  // Handshake depends only on registered count: a full queue refuses a push
  // even in a cycle that pops.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign occupancy = count_q;

  // Payload is zeroed while empty so unreset storage never shows at the port.
  assign head = out_valid ? mem_q[rd_ptr_q] : '0;
  assign {out_coh_msg, out_hprot, out_addr, out_line, out_word_mask} = head;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    drain_d    = drain_q;
    drain_done = 1'b0;
    case (drain_q)
      DR_IDLE: if (drain_req) drain_d = DR_WAIT;
      DR_WAIT: begin
        if (!drain_req)          drain_d = DR_IDLE;
        else if (count_q == '0)  drain_d = DR_DONE;
      end
      DR_DONE: begin
        drain_done = 1'b1;
        drain_d    = DR_HOLD;
      end
      DR_HOLD: if (!drain_req) drain_d = DR_IDLE;
      default: drain_d = DR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drain_q  <= DR_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drain_q  <= drain_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_coh_msg, in_hprot, in_addr, in_line, in_word_mask};
  end

endmodule

// File: tb/tb_l2_req_out_queue.sv
// Directed bench for l2_req_out_queue: flow control, ordering, wrap,
// drain handshake and asynchronous reset.
module tb_l2_req_out_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   in_coh_msg;
  logic [0:0]   in_hprot;
  logic [25:0]  in_addr;
  logic [127:0] in_line;
  logic [3:0]   in_word_mask;
  logic         out_valid;
  logic         out_ready;
  logic [4:0]   out_coh_msg;
  logic [0:0]   out_hprot;
  logic [25:0]  out_addr;
  logic [127:0] out_line;
  logic [3:0]   out_word_mask;
  logic         drain_req;
  logic         drain_done;
  logic [2:0]   occupancy;

  int unsigned n_tot = 0;
  int unsigned n_bad = 0;
  int unsigned pulses;

  l2_req_out_queue #(
    .DEPTH(4), .MSG_W(5), .HPROT_W(1), .ADDR_W(26), .LINE_W(128), .WMASK_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_coh_msg(in_coh_msg), .in_hprot(in_hprot), .in_addr(in_addr),
    .in_line(in_line), .in_word_mask(in_word_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_coh_msg(out_coh_msg), .out_hprot(out_hprot), .out_addr(out_addr),
    .out_line(out_line), .out_word_mask(out_word_mask),
    .drain_req(drain_req), .drain_done(drain_done), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Payload fields derived from the address so every field is checkable.
  task automatic drive(input logic v, input logic [25:0] a);
    in_valid     = v;
    in_addr      = a;
    in_coh_msg   = a[4:0] ^ 5'h15;
    in_hprot     = a[0];
    in_line      = {a, 102'h0} | 128'(a);
    in_word_mask = a[3:0] ^ 4'hA;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; drain_req = 1'b0;
    drive(1'b0, 26'h0);
    tick(); tick();
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_occ", 128'(occupancy), 128'd0);
    chk("rst_done", 128'(drain_done), 128'd0);
    chk("rst_addr", 128'(out_addr), 128'd0);
    rst = 1'b0;
    tick();

    // 1: single push, visible next cycle, popped that cycle
    drive(1'b1, 26'h100); out_ready = 1'b1;
    tick();
    drive(1'b0, 26'h0);
    chk("t1_valid", 128'(out_valid), 128'd1);
    chk("t1_addr", 128'(out_addr), 128'h100);
    chk("t1_msg", 128'(out_coh_msg), 128'h15);
    chk("t1_occ", 128'(occupancy), 128'd1);
    tick();
    chk("t1_valid_after", 128'(out_valid), 128'd0);
    chk("t1_occ_after", 128'(occupancy), 128'd0);

    // 2: fill with back-pressure
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("t2_ready_fill", 128'(in_ready), 128'd1);
      drive(1'b1, 26'(i));
      tick();
    end
    drive(1'b1, 26'd5);
    chk("t2_ready_full", 128'(in_ready), 128'd0);
    chk("t2_occ", 128'(occupancy), 128'd4);
    chk("t2_head", 128'(out_addr), 128'd1);
    tick();
    chk("t2_occ_hold", 128'(occupancy), 128'd4);
    chk("t2_head_stable", 128'(out_addr), 128'd1);
    chk("t2_line_stable", out_line, {26'd1, 102'h0} | 128'd1);
    chk("t2_mask_stable", 128'(out_word_mask), 128'hB);

    // 3: drain full queue; the held push is refused on the popping cycle
    out_ready = 1'b1;
    tick();
    drive(1'b0, 26'h0);
    chk("t3_occ_no_push", 128'(occupancy), 128'd3);
    chk("t3_ready", 128'(in_ready), 128'd1);
    chk("t3_head2", 128'(out_addr), 128'd2);
    tick();
    chk("t3_head3", 128'(out_addr), 128'd3);
    tick();
    chk("t3_head4", 128'(out_addr), 128'd4);
    chk("t3_hprot4", 128'(out_hprot), 128'd0);
    tick();
    chk("t3_empty", 128'(out_valid), 128'd0);
    out_ready = 1'b0;
    drive(1'b1, 26'd5);
    tick();
    drive(1'b1, 26'd6);
    chk("t3_wrap_head", 128'(out_addr), 128'd5);
    chk("t3_wrap_hprot", 128'(out_hprot), 128'd1);
    tick();
    chk("t4_occ_start", 128'(occupancy), 128'd2);

    // 4: steady push+pop at count=2
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 26'(7 + k));
      tick();
      chk("t4_occ", 128'(occupancy), 128'd2);
      chk("t4_head", 128'(out_addr), 128'(6 + k));
    end
    drive(1'b0, 26'h0);
    out_ready = 1'b0;

    // 5: drain with 3 queued (15, 16, 0x20)
    drive(1'b1, 26'h20);
    tick();
    drive(1'b0, 26'h0);
    chk("t5_occ3", 128'(occupancy), 128'd3);
    drain_req = 1'b1;
    tick();
    chk("t5_no_pulse_wait", 128'(drain_done), 128'd0);
    out_ready = 1'b1;
    chk("t5_pop_a", 128'(out_addr), 128'd15);
    tick();
    chk("t5_pop_b", 128'(out_addr), 128'd16);
    tick();
    chk("t5_pop_c", 128'(out_addr), 128'h20);
    tick();
    chk("t5_occ0", 128'(occupancy), 128'd0);
    chk("t5_no_pulse_yet", 128'(drain_done), 128'd0);
    tick();
    chk("t5_pulse", 128'(drain_done), 128'd1);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (drain_done) pulses++;
    end
    chk("t5_single_pulse", 128'(pulses), 128'd0);
    drain_req = 1'b0;
    tick();

    // drain request on an already-empty queue: pulse two cycles later
    drain_req = 1'b1;
    tick();
    chk("t5e_wait", 128'(drain_done), 128'd0);
    tick();
    chk("t5e_pulse", 128'(drain_done), 128'd1);
    drain_req = 1'b0;
    tick();
    chk("t5e_after", 128'(drain_done), 128'd0);
    tick();

    // drain request withdrawn during WAIT: no pulse
    out_ready = 1'b0;
    drive(1'b1, 26'h50);
    drain_req = 1'b1;
    tick();
    drive(1'b0, 26'h0);
    drain_req = 1'b0;
    tick();
    out_ready = 1'b1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (drain_done) pulses++;
    end
    chk("t5a_abort_no_pulse", 128'(pulses), 128'd0);
    chk("t5a_empty", 128'(occupancy), 128'd0);

    // 6: async reset with 3 entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 26'(8'h31 + i));
      tick();
    end
    drive(1'b0, 26'h0);
    chk("t6_occ3", 128'(occupancy), 128'd3);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 128'(out_valid), 128'd0);
    chk("t6_rst_occ", 128'(occupancy), 128'd0);
    chk("t6_rst_ready", 128'(in_ready), 128'd1);
    chk("t6_rst_addr", 128'(out_addr), 128'd0);
    tick();
    rst = 1'b0;
    drive(1'b1, 26'h44);
    tick();
    drive(1'b0, 26'h0);
    chk("t6_post_occ", 128'(occupancy), 128'd1);
    chk("t6_post_addr", 128'(out_addr), 128'h44);
    chk("t6_post_line", out_line, {26'h44, 102'h0} | 128'h44);
    chk("t6_post_msg", 128'(out_coh_msg), 128'h11);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
